// File: rtl/cnn_pkg.sv
// Shared CNN-block definitions: pooling controller state encoding and default widths.
package cnn_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;
  localparam int unsigned CNT_W         = 11;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = IDLE,
    ST_RUN   = RUN,
    ST_DRAIN = DRAIN,
    ST_DONE  = DONE
  } state_t;

endpackage

// File: rtl/maxpool2x2_ctrl_if.sv
// Pixel stream, line-buffer tap and pooled-result stream of the max-pool controller.
interface maxpool2x2_ctrl_if
  import cnn_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
);

  logic             s_valid;
  logic             s_ready;
  logic [WIDTH-1:0] s_data;
  logic             lb_valid_in;
  logic [WIDTH-1:0] lb_din;
  logic [WIDTH-1:0] lb_top;
  logic             m_valid;
  logic             m_ready;
  logic [WIDTH-1:0] m_data;

  // Controller side
  modport master (
    input  s_valid, s_data, lb_top, m_ready,
    output s_ready, lb_valid_in, lb_din, m_valid, m_data
  );

  // Environment side: upstream source, line buffer and downstream sink
  modport slave (
    output s_valid, s_data, lb_top, m_ready,
    input  s_ready, lb_valid_in, lb_din, m_valid, m_data
  );

endinterface

// File: rtl/max2u.sv
// Combinational unsigned two-input maximum.
module max2u #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y_c
);

  assign y_c = (a >= b) ? a : b;

endmodule

// File: rtl/maxpool2x2_ctrl.sv
// Frame sequencer and 2x2 / stride-2 max-pool scheduler around an external line buffer.
module maxpool2x2_ctrl
  import cnn_pkg::*;
#(
  parameter int unsigned WIDTH   = DEFAULT_WIDTH,
  parameter int unsigned COL_NUM = 10,
  parameter int unsigned ROW_NUM = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  output logic busy,
  output logic done,
  maxpool2x2_ctrl_if.master bus
);

  localparam logic [CNT_W-1:0] COL_LAST = CNT_W'(COL_NUM - 1);
  localparam logic [CNT_W-1:0] ROW_LAST = CNT_W'(ROW_NUM - 1);

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] col_q;
  logic [CNT_W-1:0] row_q;
  logic [WIDTH-1:0] left_max_q;
  logic [WIDTH-1:0] m_data_q;
  logic             m_valid_q;
  logic             busy_q;
  logic             done_q;

  logic             s_ready_c;
  logic             acc_c;
  logic             frame_start_c;
  logic             col_wrap_c;
  logic             last_px_c;
  logic             out_ld_c;
  logic [WIDTH-1:0] top_in_max_c;
  logic [WIDTH-1:0] right_pair_c;
  logic [WIDTH-1:0] win_max_c;

  assign acc_c         = bus.s_valid & s_ready_c;
  assign frame_start_c = (state_q == ST_IDLE) & start;
  assign col_wrap_c    = (col_q == COL_LAST);
  assign last_px_c     = col_wrap_c & (row_q == ROW_LAST);
  assign out_ld_c      = acc_c & col_q[0] & row_q[0];

  // Line buffer is fed with no added latency so its column tap stays aligned.
  assign bus.s_ready     = s_ready_c;
  assign bus.lb_valid_in = acc_c;
  assign bus.lb_din      = bus.s_data;
  assign bus.m_valid     = m_valid_q;
  assign bus.m_data      = m_data_q;
  assign busy            = busy_q;
  assign done            = done_q;

  // Column pair max, and the three-way max that closes a window.
  max2u #(.WIDTH(WIDTH)) u_max_cur   (.a(bus.lb_top),  .b(bus.s_data), .y_c(top_in_max_c));
  max2u #(.WIDTH(WIDTH)) u_max_right (.a(left_max_q),  .b(bus.lb_top), .y_c(right_pair_c));
  max2u #(.WIDTH(WIDTH)) u_max_win   (.a(right_pair_c), .b(bus.s_data), .y_c(win_max_c));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state and upstream ready; upstream stalls while a result is still held.
  always_comb begin
    state_d   = state_q;
    s_ready_c = 1'b0;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_RUN;
      ST_RUN: begin
        s_ready_c = ~m_valid_q | bus.m_ready;
        if (bus.s_valid && s_ready_c && last_px_c) state_d = ST_DRAIN;
      end
      ST_DRAIN: if (!m_valid_q || bus.m_ready) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Raster position counters and the left-column max of the current window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q      <= '0;
      row_q      <= '0;
      left_max_q <= '0;
    end else if (frame_start_c) begin
      col_q      <= '0;
      row_q      <= '0;
      left_max_q <= '0;
    end else if (acc_c) begin
      if (col_wrap_c) begin
        col_q <= '0;
        row_q <= (row_q == ROW_LAST) ? '0 : row_q + CNT_W'(1);
      end else begin
        col_q <= col_q + CNT_W'(1);
      end
      if (!col_q[0]) left_max_q <= top_in_max_c;
    end
  end

  // Result register; a load wins over a same-cycle consume.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
    end else if (out_ld_c) begin
      m_valid_q <= 1'b1;
      m_data_q  <= win_max_c;
    end else if (m_valid_q && bus.m_ready) begin
      m_valid_q <= 1'b0;
    end
  end

  // Registered status flags derived from the upcoming state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      busy_q <= (state_d == ST_RUN) || (state_d == ST_DRAIN);
      done_q <= (state_d == ST_DONE);
    end
  end

endmodule

// File: tb/tb_maxpool2x2_ctrl.sv
// Bench for maxpool2x2_ctrl on a 4x4 frame with a behavioural line buffer alongside.
module tb_maxpool2x2_ctrl;

  localparam int W    = 8;
  localparam int COLS = 4;
  localparam int ROWS = 4;
  localparam int NPIX = COLS * ROWS;
  localparam int NRES = (COLS / 2) * (ROWS / 2);

  typedef logic [W-1:0] frame_t [NPIX];

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic busy;
  logic done;

  int checks = 0;
  int failures = 0;

  logic [W-1:0] obs_q[$];
  logic [W-1:0] exp_q[$];
  int           done_cnt = 0;
  int           res_at_done = 0;
  int           lb_pulses = 0;
  logic         prev_stall = 1'b0;
  logic [W-1:0] prev_data = '0;
  logic [W-1:0] lb_mem [COLS];

  maxpool2x2_ctrl_if #(.WIDTH(W)) bus ();

  maxpool2x2_ctrl #(.WIDTH(W), .COL_NUM(COLS), .ROW_NUM(ROWS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .busy  (busy),
    .done  (done),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Line buffer: returns the pixel accepted one full row earlier.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < COLS; i++) lb_mem[i] <= '0;
    end else if (bus.lb_valid_in) begin
      lb_mem[0] <= bus.lb_din;
      for (int i = 1; i < COLS; i++) lb_mem[i] <= lb_mem[i-1];
    end
  end
  assign bus.lb_top = lb_mem[COLS-1];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Output-side monitor: handshakes, line-buffer pushes, done pulses, hold stability.
  always @(negedge clk) begin
    if (rst_n && prev_stall) chk("m_data_hold", bus.m_data, prev_data);
    if (bus.m_valid && bus.m_ready) obs_q.push_back(bus.m_data);
    if (bus.lb_valid_in) lb_pulses++;
    if (done) begin
      done_cnt++;
      res_at_done = obs_q.size();
    end
    prev_stall = rst_n & bus.m_valid & ~bus.m_ready;
    prev_data  = bus.m_data;
  end

  // Reference: maximum of each non-overlapping 2x2 window, windows in raster order.
  function automatic void build_exp(input frame_t px);
    exp_q.delete();
    for (int wr = 0; wr < ROWS / 2; wr++) begin
      for (int wc = 0; wc < COLS / 2; wc++) begin
        logic [W-1:0] m;
        m = '0;
        for (int dr = 0; dr < 2; dr++) begin
          for (int dc = 0; dc < 2; dc++) begin
            if (px[(2*wr + dr)*COLS + 2*wc + dc] > m) m = px[(2*wr + dr)*COLS + 2*wc + dc];
          end
        end
        exp_q.push_back(m);
      end
    end
  endfunction

  task automatic begin_frame(input frame_t px);
    @(posedge clk); #1;
    start = 1'b1;
    obs_q.delete();
    done_cnt = 0;
    res_at_done = 0;
    build_exp(px);
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", busy, 1);
  endtask

  task automatic run_frame(input frame_t px, input int first, input int vprob, input int rprob,
                           input bit poke, input int budget, output int next_idx);
    int idx;
    int cyc;
    bit took;
    idx = first;
    cyc = 0;
    while (idx < NPIX && cyc < budget) begin
      if (!bus.s_valid && int'($urandom_range(99)) < vprob) begin
        bus.s_valid = 1'b1;
        bus.s_data  = px[idx];
      end
      bus.m_ready = (int'($urandom_range(99)) < rprob);
      start = poke ? 1'($urandom_range(1)) : 1'b0;
      @(negedge clk);
      took = bus.s_valid && bus.s_ready;
      @(posedge clk); #1;
      if (took) begin
        bus.s_valid = 1'b0;
        idx++;
      end
      cyc++;
    end
    bus.s_valid = 1'b0;
    start = 1'b0;
    next_idx = idx;
  endtask

  task automatic end_frame(input int rprob, input bit poke, input string tag);
    bit seen;
    int cyc;
    seen = 1'b0;
    cyc = 0;
    bus.s_valid = 1'b0;
    while (!seen && cyc < 200) begin
      bus.m_ready = (int'($urandom_range(99)) < rprob);
      start = poke ? 1'($urandom_range(1)) : 1'b0;
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
      else begin
        @(posedge clk); #1;
      end
      cyc++;
    end
    start = 1'b0;
    #1;
    chk({tag, "_done_seen"}, 32'(seen), 1);
    chk({tag, "_n_results"}, obs_q.size(), NRES);
    for (int i = 0; i < NRES; i++)
      chk($sformatf("%s_result%0d", tag, i), (i < obs_q.size()) ? 32'(obs_q[i]) : 'x, exp_q[i]);
    chk({tag, "_results_before_done"}, res_at_done, NRES);
    chk({tag, "_done_once"}, done_cnt, 1);
    chk({tag, "_busy_at_done"}, busy, 0);
  endtask

  task automatic do_frame(input frame_t px, input int vprob, input int rprob, input bit poke,
                          input string tag);
    int n;
    begin_frame(px);
    run_frame(px, 0, vprob, rprob, poke, 400, n);
    chk({tag, "_accepted"}, n, NPIX);
    end_frame(rprob, poke, tag);
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_m_valid"}, bus.m_valid, 0);
    chk({tag, "_m_data"}, bus.m_data, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_s_ready"}, bus.s_ready, 0);
    chk({tag, "_lb_valid_in"}, bus.lb_valid_in, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    frame_t raster;
    frame_t sat;
    frame_t tl;
    int n;
    int lb0;

    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.m_ready = 1'b0;
    for (int i = 0; i < NPIX; i++) raster[i] = W'(i);

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_idle_outputs("post_reset");

    // Raster frame, always ready, then confirm a single done and idle afterwards
    do_frame(raster, 100, 100, 1'b0, "raster");
    repeat (3) @(posedge clk);
    #1;
    chk("raster_done_total", done_cnt, 1);
    chk("raster_busy_after", busy, 0);

    // Saturation: 0 at each window's bottom-right, 255 elsewhere
    for (int i = 0; i < NPIX; i++) sat[i] = 8'd255;
    sat[5] = 8'd0; sat[7] = 8'd0; sat[13] = 8'd0; sat[15] = 8'd0;
    do_frame(sat, 100, 100, 1'b0, "saturate");

    // Top-left of each window holds the maximum
    for (int i = 0; i < NPIX; i++) tl[i] = W'($urandom_range(100));
    for (int wr = 0; wr < ROWS / 2; wr++)
      for (int wc = 0; wc < COLS / 2; wc++)
        tl[(2*wr)*COLS + 2*wc] = W'(150 + $urandom_range(105));
    do_frame(tl, 100, 100, 1'b0, "top_left");

    // Backpressure: downstream never ready, first result holds the stream
    begin_frame(raster);
    run_frame(raster, 0, 100, 0, 1'b0, 12, n);
    chk("bp_accepted_before_stall", n, 6);
    lb0 = lb_pulses;
    bus.s_valid = 1'b1;
    bus.s_data  = raster[6];
    bus.m_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_s_ready", bus.s_ready, 0);
      chk("bp_m_valid", bus.m_valid, 1);
      chk("bp_m_data", bus.m_data, exp_q[0]);
      @(posedge clk); #1;
    end
    chk("bp_no_lb_push", lb_pulses, lb0);
    bus.s_valid = 1'b0;
    run_frame(raster, 6, 100, 100, 1'b0, 100, n);
    chk("bp_accepted", n, NPIX);
    end_frame(100, 1'b0, "backpressure");

    // Start pulses in RUN/DRAIN ignored; back-to-back frame right after done
    do_frame(raster, 100, 100, 1'b1, "start_busy");
    do_frame(raster, 100, 100, 1'b0, "back_to_back");

    // Reset after six pixels, then a full clean frame
    begin_frame(raster);
    run_frame(raster, 0, 100, 100, 1'b0, 6, n);
    chk("rst_mid_accepted", n, 6);
    rst_n = 1'b0;
    @(negedge clk);
    check_idle_outputs("rst_mid");
    @(posedge clk); #1;
    rst_n = 1'b1;
    do_frame(raster, 100, 100, 1'b0, "after_reset");

    // Sparse input and random downstream readiness
    for (int r = 0; r < 3; r++) do_frame(raster, 50, 50, 1'b0, $sformatf("sparse%0d", r));

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
